// File: rtl/cal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cal_pkg
// Description : Shared widths and calendar helper functions (leap year,
//               month length, small binary-to-BCD conversion).
// Revision    : 1.0 - initial release
// ============================================================================
package cal_pkg;

    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int DOW_W   = 3;

    typedef logic [MONTH_W-1:0] month_t;
    typedef logic [DAY_W-1:0]   day_t;
    typedef logic [DOW_W-1:0]   dow_t;

    function automatic logic is_leap(input int unsigned year);
        return (((year % 4) == 0) && ((year % 100) != 0)) || ((year % 400) == 0);
    endfunction

    function automatic day_t days_in_month(input month_t month, input int unsigned year);
        day_t days;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
            4'd2:                    days = is_leap(year) ? 5'd29 : 5'd28;
            default:                 days = 5'd31;
        endcase
        return days;
    endfunction

    // Input must be 0..99; yields two packed BCD digits.
    function automatic logic [7:0] bin2bcd_small(input logic [6:0] value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 7'd10);
        ones = 4'(value % 7'd10);
        return {tens, ones};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cal_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : cal_bcd_conv
// Description : Registered binary-to-BCD conversion of year/month/day; adds
//               one cycle of latency relative to the binary date.
// Revision    : 1.0 - initial release
// ============================================================================
module cal_bcd_conv
    import cal_pkg::*;
#(
    parameter int YEAR_W    = 14,
    parameter int RST_YEAR  = 2000,
    parameter int RST_MONTH = 1,
    parameter int RST_DAY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [YEAR_W-1:0] year,
    input  month_t            month,
    input  day_t              day,
    output logic [15:0]       year_bcd,
    output logic [7:0]        month_bcd,
    output logic [7:0]        day_bcd
);

    function automatic logic [15:0] year_to_bcd(input int unsigned y);
        return {bin2bcd_small(7'(y / 100)), bin2bcd_small(7'(y % 100))};
    endfunction

    localparam logic [15:0] c_rst_year_bcd  = year_to_bcd(RST_YEAR);
    localparam logic [7:0]  c_rst_month_bcd = bin2bcd_small(7'(RST_MONTH));
    localparam logic [7:0]  c_rst_day_bcd   = bin2bcd_small(7'(RST_DAY));

    logic [15:0] r_year_bcd;
    logic [7:0]  r_month_bcd;
    logic [7:0]  r_day_bcd;

    // Reset loads the reset date directly so BCD agrees with binary right away.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_year_bcd  <= c_rst_year_bcd;
            r_month_bcd <= c_rst_month_bcd;
            r_day_bcd   <= c_rst_day_bcd;
        end else begin
            r_year_bcd  <= year_to_bcd(32'(year));
            r_month_bcd <= bin2bcd_small(7'(month));
            r_day_bcd   <= bin2bcd_small(7'(day));
        end
    end

    assign year_bcd  = r_year_bcd;
    assign month_bcd = r_month_bcd;
    assign day_bcd   = r_day_bcd;

endmodule
`default_nettype wire

// File: rtl/calendar_counter.sv
`default_nettype none
// ============================================================================
// Module      : calendar_counter
// Description : Year/month/day/day-of-week counter with validated load,
//               Gregorian leap years and registered BCD outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module calendar_counter
    import cal_pkg::*;
#(
    parameter int YEAR_W    = 14,
    parameter int YEAR_MIN  = 2000,
    parameter int YEAR_MAX  = 2099,
    parameter int RST_YEAR  = 2000,
    parameter int RST_MONTH = 1,
    parameter int RST_DAY   = 1,
    parameter int RST_DOW   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              set_valid,
    input  logic [YEAR_W-1:0] set_year,
    input  logic [3:0]        set_month,
    input  logic [4:0]        set_day,
    input  logic [2:0]        set_dow,
    output logic              set_err,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        month,
    output logic [4:0]        day,
    output logic [2:0]        dow,
    output logic              leap,
    output logic [15:0]       year_bcd,
    output logic [7:0]        month_bcd,
    output logic [7:0]        day_bcd,
    output logic              wrap
);

    localparam logic [YEAR_W-1:0] c_year_min  = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] c_year_max  = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] c_rst_year  = YEAR_W'(RST_YEAR);
    localparam month_t            c_rst_month = MONTH_W'(RST_MONTH);
    localparam day_t              c_rst_day   = DAY_W'(RST_DAY);
    localparam dow_t              c_rst_dow   = DOW_W'(RST_DOW);
    localparam logic              c_rst_leap  = is_leap(RST_YEAR);
    localparam int                c_rst_dim   = int'(days_in_month(c_rst_month, RST_YEAR));

    if (YEAR_MAX >= 10000) begin : g_chk_year_max
        $error("calendar_counter: YEAR_MAX must be below 10000");
    end
    if ((YEAR_MIN > YEAR_MAX) || ((64'd1 << YEAR_W) <= 64'(YEAR_MAX))) begin : g_chk_year_range
        $error("calendar_counter: YEAR_MIN/YEAR_MAX inconsistent with YEAR_W");
    end
    if ((RST_YEAR < YEAR_MIN) || (RST_YEAR > YEAR_MAX) ||
        (RST_MONTH < 1) || (RST_MONTH > 12) ||
        (RST_DAY < 1) || (RST_DAY > c_rst_dim) ||
        (RST_DOW < 0) || (RST_DOW > 6)) begin : g_chk_rst_date
        $error("calendar_counter: RST_* parameters do not form a valid date");
    end

    logic [YEAR_W-1:0] r_year;
    month_t            r_month;
    day_t              r_day;
    dow_t              r_dow;
    logic              r_leap;
    logic              r_set_err;
    logic              r_wrap;

    day_t              w_dim;
    day_t              w_set_dim;
    logic              w_set_ok;
    logic [YEAR_W-1:0] w_year_nxt;
    month_t            w_month_nxt;
    day_t              w_day_nxt;
    dow_t              w_dow_nxt;
    logic              w_set_err_nxt;
    logic              w_wrap_nxt;

    assign w_dim     = days_in_month(r_month, 32'(r_year));
    assign w_set_dim = days_in_month(set_month, 32'(set_year));
    assign w_set_ok  = (set_year >= c_year_min) && (set_year <= c_year_max) &&
                       (set_month >= 4'd1) && (set_month <= 4'd12) &&
                       (set_day >= 5'd1) && (set_day <= w_set_dim) &&
                       (set_dow <= 3'd6);

    // A load request always takes priority over the tick, accepted or not.
    always_comb begin
        w_year_nxt    = r_year;
        w_month_nxt   = r_month;
        w_day_nxt     = r_day;
        w_dow_nxt     = r_dow;
        w_set_err_nxt = 1'b0;
        w_wrap_nxt    = 1'b0;
        if (set_valid) begin
            if (w_set_ok) begin
                w_year_nxt  = set_year;
                w_month_nxt = set_month;
                w_day_nxt   = set_day;
                w_dow_nxt   = set_dow;
            end else begin
                w_set_err_nxt = 1'b1;
            end
        end else if (clk_en) begin
            w_dow_nxt = (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;
            if (r_day < w_dim) begin
                w_day_nxt = r_day + 5'd1;
            end else begin
                w_day_nxt = 5'd1;
                if (r_month == 4'd12) begin
                    w_month_nxt = 4'd1;
                    if (r_year == c_year_max) begin
                        w_year_nxt = c_year_min;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_year_nxt = r_year + YEAR_W'(1);
                    end
                end else begin
                    w_month_nxt = r_month + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_year    <= c_rst_year;
            r_month   <= c_rst_month;
            r_day     <= c_rst_day;
            r_dow     <= c_rst_dow;
            r_leap    <= c_rst_leap;
            r_set_err <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_year    <= w_year_nxt;
            r_month   <= w_month_nxt;
            r_day     <= w_day_nxt;
            r_dow     <= w_dow_nxt;
            r_leap    <= is_leap(32'(w_year_nxt));
            r_set_err <= w_set_err_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    cal_bcd_conv #(
        .YEAR_W    (YEAR_W),
        .RST_YEAR  (RST_YEAR),
        .RST_MONTH (RST_MONTH),
        .RST_DAY   (RST_DAY)
    ) u_bcd_conv (
        .clk       (clk),
        .rst       (rst),
        .year      (r_year),
        .month     (r_month),
        .day       (r_day),
        .year_bcd  (year_bcd),
        .month_bcd (month_bcd),
        .day_bcd   (day_bcd)
    );

    assign year    = r_year;
    assign month   = r_month;
    assign day     = r_day;
    assign dow     = r_dow;
    assign leap    = r_leap;
    assign set_err = r_set_err;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_calendar_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_calendar_counter
// Description : Scoreboard bench for calendar_counter; two instances
//               (YEAR_MAX 2099 and 2199) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calendar_counter;

    logic        clk = 1'b0;
    logic        rst, clk_en, set_valid;
    logic [13:0] set_year;
    logic [3:0]  set_month;
    logic [4:0]  set_day;
    logic [2:0]  set_dow;

    logic        a_set_err, a_leap, a_wrap, b_set_err, b_leap, b_wrap;
    logic [13:0] a_year, b_year;
    logic [3:0]  a_month, b_month;
    logic [4:0]  a_day, b_day;
    logic [2:0]  a_dow, b_dow;
    logic [15:0] a_year_bcd, b_year_bcd;
    logic [7:0]  a_month_bcd, a_day_bcd, b_month_bcd, b_day_bcd;

    always #5 clk = ~clk;

    calendar_counter dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .set_valid(set_valid),
        .set_year(set_year), .set_month(set_month), .set_day(set_day), .set_dow(set_dow),
        .set_err(a_set_err), .year(a_year), .month(a_month), .day(a_day), .dow(a_dow),
        .leap(a_leap), .year_bcd(a_year_bcd), .month_bcd(a_month_bcd), .day_bcd(a_day_bcd),
        .wrap(a_wrap)
    );

    calendar_counter #(.YEAR_MAX(2199)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .set_valid(set_valid),
        .set_year(set_year), .set_month(set_month), .set_day(set_day), .set_dow(set_dow),
        .set_err(b_set_err), .year(b_year), .month(b_month), .day(b_day), .dow(b_dow),
        .leap(b_leap), .year_bcd(b_year_bcd), .month_bcd(b_month_bcd), .day_bcd(b_day_bcd),
        .wrap(b_wrap)
    );

    typedef struct {
        logic [31:0] year, month, day, dow, leap;
        logic [31:0] year_bcd, month_bcd, day_bcd, set_err, wrap;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    int a_y, a_m, a_d, a_w;
    int b_y, b_m, b_d, b_w;

    // ---------------- reference model: plain calendar arithmetic ----------------
    function automatic bit m_leap(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int m_dim(int m, int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 0;
        return t[m-1] + ((m == 2 && m_leap(y)) ? 1 : 0);
    endfunction

    function automatic logic [31:0] m_bcd(int v, int ndig);
        logic [31:0] r = 0;
        for (int i = 0; i < ndig; i++) begin
            r = r | (32'(v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model(input int ymax, inout int y, inout int m, inout int d, inout int w,
                         input bit r, input bit en, input bit sv,
                         input int sy, input int sm, input int sd, input int sw,
                         output exp_t e);
        int py, pm, pd;
        py = y; pm = m; pd = d;
        e.set_err = 0;
        e.wrap    = 0;
        if (r) begin
            y = 2000; m = 1; d = 1; w = 6;
            py = y; pm = m; pd = d;
        end else if (sv) begin
            if (sy >= 2000 && sy <= ymax && sm >= 1 && sm <= 12 &&
                sd >= 1 && sd <= m_dim(sm, sy) && sw <= 6) begin
                y = sy; m = sm; d = sd; w = sw;
            end else begin
                e.set_err = 1;
            end
        end else if (en) begin
            d++;
            if (d > m_dim(m, y)) begin
                d = 1;
                m++;
                if (m > 12) begin
                    m = 1;
                    y++;
                    if (y > ymax) begin
                        y = 2000;
                        e.wrap = 1;
                    end
                end
            end
            w = (w + 1) % 7;
        end
        e.year      = 32'(y);
        e.month     = 32'(m);
        e.day       = 32'(d);
        e.dow       = 32'(w);
        e.leap      = m_leap(y) ? 32'd1 : 32'd0;
        e.year_bcd  = m_bcd(py, 4);
        e.month_bcd = m_bcd(pm, 2);
        e.day_bcd   = m_bcd(pd, 2);
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input bit r, input bit en, input bit sv,
                        input int y, input int m, input int d, input int w);
        exp_t ea, eb;
        @(negedge clk);
        rst = r; clk_en = en; set_valid = sv;
        set_year = 14'(y); set_month = 4'(m); set_day = 5'(d); set_dow = 3'(w);
        model(2099, a_y, a_m, a_d, a_w, r, en, sv, y, m, d, w, ea);
        model(2199, b_y, b_m, b_d, b_w, r, en, sv, y, m, d, w, eb);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input bit en, input int y, input int m, input int d, input int w);
        step(0, en, 1, y, m, d, w);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string who, input exp_t act, input exp_t e);
        chk({who, ".year"},      act.year,      e.year);
        chk({who, ".month"},     act.month,     e.month);
        chk({who, ".day"},       act.day,       e.day);
        chk({who, ".dow"},       act.dow,       e.dow);
        chk({who, ".leap"},      act.leap,      e.leap);
        chk({who, ".year_bcd"},  act.year_bcd,  e.year_bcd);
        chk({who, ".month_bcd"}, act.month_bcd, e.month_bcd);
        chk({who, ".day_bcd"},   act.day_bcd,   e.day_bcd);
        chk({who, ".set_err"},   act.set_err,   e.set_err);
        chk({who, ".wrap"},      act.wrap,      e.wrap);
    endtask

    always @(posedge clk) begin
        exp_t ea, eb, aa, ab;
        #1;
        if (qa.size() != 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            aa.year = 32'(a_year);   aa.month = 32'(a_month); aa.day = 32'(a_day);
            aa.dow = 32'(a_dow);     aa.leap = 32'(a_leap);   aa.year_bcd = 32'(a_year_bcd);
            aa.month_bcd = 32'(a_month_bcd); aa.day_bcd = 32'(a_day_bcd);
            aa.set_err = 32'(a_set_err);     aa.wrap = 32'(a_wrap);
            ab.year = 32'(b_year);   ab.month = 32'(b_month); ab.day = 32'(b_day);
            ab.dow = 32'(b_dow);     ab.leap = 32'(b_leap);   ab.year_bcd = 32'(b_year_bcd);
            ab.month_bcd = 32'(b_month_bcd); ab.day_bcd = 32'(b_day_bcd);
            ab.set_err = 32'(b_set_err);     ab.wrap = 32'(b_wrap);
            cmp_all("a", aa, ea);
            cmp_all("b", ab, eb);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b0; set_valid = 1'b0;
        set_year = '0; set_month = '0; set_day = '0; set_dow = '0;

        step(1, 0, 0, 0, 0, 0, 0);
        repeat (31) tick();
        idle();

        load(0, 2000, 2, 28, 1); tick(); idle();
        load(0, 2100, 2, 28, 1); tick(); idle();
        load(0, 2099, 12, 31, 4); tick(); idle(); idle();

        load(0, 2001, 2, 29, 3); idle();
        load(0, 2005, 13, 1, 0); idle();
        load(0, 2005, 3, 0, 0);  idle();
        load(0, 2005, 3, 1, 7);  idle();
        load(0, 1999, 12, 31, 0); idle();

        load(1, 2024, 6, 15, 6); idle();
        load(1, 2001, 2, 29, 0); idle();

        step(1, 1, 1, 2024, 6, 15, 6); idle();
        load(0, 2050, 5, 5, 3); idle();
        step(1, 1, 1, 2001, 2, 29, 0); idle();

        for (int i = 0; i < 4000; i++) begin
            bit r, en, sv;
            int y, m, d, w, sel;
            r   = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 3) != 0);
            sv  = ($urandom_range(0, 9) == 0);
            sel = int'($urandom_range(0, 3));
            if (sel == 0) begin
                y = int'($urandom_range(1990, 2210));
                m = int'($urandom_range(0, 15));
                d = int'($urandom_range(0, 31));
                w = int'($urandom_range(0, 7));
            end else if (sel == 3) begin
                y = ($urandom_range(0, 1) != 0) ? 2099 : 2199;
                m = 12;
                d = 31;
                w = int'($urandom_range(0, 6));
            end else begin
                y = int'($urandom_range(2000, 2199));
                m = int'($urandom_range(1, 12));
                d = (sel == 1) ? m_dim(m, y) : int'($urandom_range(1, m_dim(m, y)));
                w = int'($urandom_range(0, 6));
            end
            step(r, en, sv, y, m, d, w);
        end

        idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(qa.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
